uart_tx_word_arbiter: RTL and testbench

//  Shares the UART transmit path between N_REQ requesters, each sending one NB_WORD word.

---
 rtl/uart_tx_word_arbiter.sv | 97 +++++++++
 tb/tb_uart_tx_word_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_word_arbiter.sv
// Round-robin arbiter that lets N_REQ requesters share one UART transmitter.
// The granted word is sent LSB byte first, one byte per uart_top start/done handshake.
module uart_tx_word_arbiter #(
    parameter int N_REQ   = 2,
    parameter int NB_WORD = 32,
    parameter int NB_DATA = 8
) (
    input  logic                     clk,
    input  logic                     i_rst_n,
    input  logic [N_REQ-1:0]         i_req,
    input  logic [N_REQ*NB_WORD-1:0] i_word,
    output logic [N_REQ-1:0]         o_gnt,
    output logic [N_REQ-1:0]         o_done,
    output logic                     o_busy,
    output logic                     o_tx_start,
    output logic [NB_DATA-1:0]       o_wdata,
    input  logic                     i_tx_full,
    input  logic                     i_tx_done
);
    localparam int NB_BYTES = NB_WORD / NB_DATA;
    localparam int IDX_W    = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
    localparam int PTR_W    = $clog2(N_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_BYTES - 1);
    localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(N_REQ - 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q;
    logic [PTR_W-1:0]   winner;
    logic [IDX_W-1:0]   idx_q;
    logic [NB_WORD-1:0] word_q;
    logic [N_REQ-1:0]   gnt_q;

    // First requesting index above the last winner, wrapping; scanning downward
    // and overwriting leaves the nearest candidate as the final value.
    always_comb begin
        // NOTE: assigning a default before any conditional write keeps this block
        // purely combinational; omitting it would infer a latch.
        winner = rr_ptr_q;
        for (int i = N_REQ; i >= 1; i--) begin
            if (i_req[(int'(rr_ptr_q) + i) % N_REQ]) begin
                winner = PTR_W'((int'(rr_ptr_q) + i) % N_REQ);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|i_req) state_d = SEND;
            SEND:    if (!i_tx_full) state_d = WAIT;
            WAIT:    if (i_tx_done) state_d = (idx_q == LAST_IDX) ? DONE : SEND;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // NOTE: non-blocking assignments here so every register samples the
            // pre-edge values of the others, independent of statement order.
            state_q  <= IDLE;
            rr_ptr_q <= PTR_RST;
            idx_q    <= '0;
            // NOTE: the latched word is a plain register, so it is reset too;
            // o_wdata is read straight from it and must be 0 during reset.
            word_q   <= '0;
            gnt_q    <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (|i_req) begin
                        word_q   <= i_word[int'(winner)*NB_WORD +: NB_WORD];
                        gnt_q    <= N_REQ'(1) << winner;
                        rr_ptr_q <= winner;
                        idx_q    <= '0;
                    end
                end
                WAIT: begin
                    if (i_tx_done && (idx_q != LAST_IDX)) idx_q <= idx_q + 1'b1;
                end
                DONE:    gnt_q <= '0;
                default: ;
            endcase
        end
    end

    // Start is decoded from state so it can only be high for a single SEND cycle.
    assign o_gnt      = gnt_q;
    assign o_busy     = (state_q != IDLE);
    assign o_tx_start = (state_q == SEND) && !i_tx_full;
    assign o_done     = (state_q == DONE) ? gnt_q : '0;
    assign o_wdata    = word_q[int'(idx_q)*NB_DATA +: NB_DATA];

endmodule

// File: tb/tb_uart_tx_word_arbiter.sv
// Scoreboard bench: tests push expected (grant, byte) pairs; monitors pop them
// whenever a DUT issues a start or done. A 3-requester 16-bit build runs alongside.
`timescale 1ns/1ps
module tb_uart_tx_word_arbiter;

    typedef struct packed {
        logic [2:0] gnt;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        i_rst_n;
    logic [1:0]  req;
    logic [63:0] word;
    logic [1:0]  gnt, done;
    logic        busy, tx_start, tx_full, tx_done, resp_done, spur_done;
    logic [7:0]  wdata;

    logic [2:0]  req3;
    logic [47:0] word3;
    logic [2:0]  gnt3, done3;
    logic        busy3, start3, full3, tx_done3;
    logic [7:0]  wdata3;

    assign tx_done = resp_done | spur_done;

    uart_tx_word_arbiter #(.N_REQ(2), .NB_WORD(32), .NB_DATA(8)) dut (
        .clk(clk), .i_rst_n(i_rst_n), .i_req(req), .i_word(word),
        .o_gnt(gnt), .o_done(done), .o_busy(busy), .o_tx_start(tx_start),
        .o_wdata(wdata), .i_tx_full(tx_full), .i_tx_done(tx_done)
    );

    uart_tx_word_arbiter #(.N_REQ(3), .NB_WORD(16), .NB_DATA(8)) dut3 (
        .clk(clk), .i_rst_n(i_rst_n), .i_req(req3), .i_word(word3),
        .o_gnt(gnt3), .o_done(done3), .o_busy(busy3), .o_tx_start(start3),
        .o_wdata(wdata3), .i_tx_full(full3), .i_tx_done(tx_done3)
    );

    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    int   last_done_cyc = 0;
    int   tx_dly = 3;
    exp_t q_main[$];
    exp_t q3[$];
    logic [2:0] qd_main[$];
    logic [2:0] qd3[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic push_word(input bit to3, input logic [2:0] g, input logic [31:0] w, input int nb);
        exp_t e;
        for (int b = 0; b < nb; b++) begin
            e.gnt  = g;
            e.data = w[b*8 +: 8];
            if (to3) q3.push_back(e);
            else q_main.push_back(e);
        end
        if (to3) qd3.push_back(g);
        else qd_main.push_back(g);
    endtask

    function automatic logic hit(input int sel);
        case (sel)
            0:       return gnt != 0;
            1:       return done != 0;
            2:       return tx_start;
            3:       return gnt3 != 0;
            4:       return done3 != 0;
            default: return 1'b0;
        endcase
    endfunction

    // Bounded wait on a DUT event, evaluated at negedges; timing out is a failed check.
    task automatic wait_ev(input int sel, input string name);
        for (int i = 0; i < 2000 && !hit(sel); i++) @(negedge clk);
        check(name, 32'(hit(sel)), 1);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // uart_top stand-ins: pulse done tx_dly cycles after each start.
    initial begin : resp_main
        int cnt = 0;
        resp_done = 1'b0;
        forever begin
            @(negedge clk);
            resp_done = 1'b0;
            if (!i_rst_n) cnt = 0;
            else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        resp_done = 1'b1;
                        last_done_cyc = cyc;
                    end
                end
                if (tx_start) begin
                    check("start_without_pending_byte", 32'(cnt), 0);
                    cnt = tx_dly;
                end
            end
        end
    end

    initial begin : resp_3
        int cnt = 0;
        tx_done3 = 1'b0;
        forever begin
            @(negedge clk);
            tx_done3 = 1'b0;
            if (!i_rst_n) cnt = 0;
            else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) tx_done3 = 1'b1;
                end
                if (start3) cnt = 2;
            end
        end
    end

    initial begin : mon_main
        exp_t e;
        forever begin
            @(negedge clk);
            if (i_rst_n) begin
                if (tx_start) begin
                    check("start_expected", 32'(q_main.size() != 0), 1);
                    if (q_main.size() != 0) begin
                        e = q_main.pop_front();
                        check("start_gnt", 32'(gnt), 32'(e.gnt));
                        check("start_byte", 32'(wdata), 32'(e.data));
                    end
                end
                if (done != 0) begin
                    check("done_expected", 32'(qd_main.size() != 0), 1);
                    if (qd_main.size() != 0) check("done_vec", 32'(done), 32'(qd_main.pop_front()));
                    check("done_latency", 32'(cyc - last_done_cyc), 1);
                end
            end
        end
    end

    initial begin : mon_3
        exp_t e;
        forever begin
            @(negedge clk);
            if (i_rst_n) begin
                if (start3) begin
                    check("n3_start_expected", 32'(q3.size() != 0), 1);
                    if (q3.size() != 0) begin
                        e = q3.pop_front();
                        check("n3_start_gnt", 32'(gnt3), 32'(e.gnt));
                        check("n3_start_byte", 32'(wdata3), 32'(e.data));
                    end
                end
                if (done3 != 0) begin
                    check("n3_done_expected", 32'(qd3.size() != 0), 1);
                    if (qd3.size() != 0) check("n3_done_vec", 32'(done3), 32'(qd3.pop_front()));
                end
            end
        end
    end

    initial begin
        i_rst_n   = 1'b0;
        req       = '0;
        word      = {32'h44332211, 32'hDDCCBBAA};
        tx_full   = 1'b0;
        spur_done = 1'b0;
        req3      = '0;
        word3     = {16'hB2A2, 16'hB1A1, 16'hB0A0};
        full3     = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_gnt", 32'(gnt), 0);
        check("rst_done", 32'(done), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_start", 32'(tx_start), 0);
        check("rst_wdata", 32'(wdata), 0);
        check("rst_n3_gnt", 32'(gnt3), 0);
        check("rst_n3_busy", 32'(busy3), 0);
        i_rst_n = 1'b1;
        @(negedge clk);

        // 1: single requester, slow uart
        tx_dly = 20;
        push_word(0, 3'b001, 32'hDDCCBBAA, 4);
        req = 2'b01;
        @(negedge clk);
        check("t1_gnt_latency", 32'(gnt), 32'h1);
        check("t1_start_latency", 32'(tx_start), 1);
        req = 2'b00;
        wait_ev(1, "t1_done_seen");
        @(negedge clk);

        // 2: both requesting from reset -> alternating grants
        tx_dly = 2;
        i_rst_n = 1'b0;
        req = 2'b11;
        push_word(0, 3'b001, 32'hDDCCBBAA, 4);
        push_word(0, 3'b010, 32'h44332211, 4);
        push_word(0, 3'b001, 32'hDDCCBBAA, 4);
        push_word(0, 3'b010, 32'h44332211, 4);
        @(negedge clk);
        i_rst_n = 1'b1;
        for (int g = 0; g < 4; g++) begin
            wait_ev(0, "t2_gnt_seen");
            check("t2_gnt_order", 32'(gnt), (g % 2 == 0) ? 32'h1 : 32'h2);
            check("t2_gnt_onehot", 32'($onehot(gnt)), 1);
            if (g == 3) req = 2'b00;
            wait_ev(1, "t2_done_seen");
            @(negedge clk);
            check("t2_busy_idle_gap", 32'(busy), 0);
            if (g < 3) begin
                @(negedge clk);
                check("t2_busy_regrant", 32'(busy), 1);
            end
        end

        // 3: fifo full for the first five SEND cycles
        tx_full = 1'b1;
        req = 2'b01;
        push_word(0, 3'b001, 32'hDDCCBBAA, 4);
        @(negedge clk);
        check("t3_gnt", 32'(gnt), 32'h1);
        req = 2'b00;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            check("t3_no_start_while_full", 32'(tx_start), 0);
            check("t3_wdata_stable", 32'(wdata), 32'hAA);
        end
        @(posedge clk);
        #1 tx_full = 1'b0;
        @(negedge clk);
        check("t3_start_after_full", 32'(tx_start), 1);
        wait_ev(1, "t3_done_seen");
        @(negedge clk);

        // 4: word and request change after grant; spurious done in IDLE
        push_word(0, 3'b001, 32'hDDCCBBAA, 4);
        req = 2'b01;
        @(negedge clk);
        check("t4_gnt", 32'(gnt), 32'h1);
        word[31:0] = 32'h11111111;
        req = 2'b00;
        wait_ev(1, "t4_done_seen");
        @(negedge clk);
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        check("t4_spurious_busy", 32'(busy), 0);
        check("t4_spurious_start", 32'(tx_start), 0);
        @(negedge clk);
        check("t4_spurious_gnt", 32'(gnt), 0);
        word[31:0] = 32'hDDCCBBAA;

        // 5: asynchronous reset while waiting on the second byte
        tx_dly = 3;
        push_word(0, 3'b001, 32'h0000BBAA, 2);
        void'(qd_main.pop_back());
        req = 2'b01;
        @(negedge clk);
        req = 2'b00;
        wait_ev(2, "t5_start1_seen");
        @(negedge clk);
        wait_ev(2, "t5_start2_seen");
        @(negedge clk);
        #2 i_rst_n = 1'b0;
        #1;
        check("t5_async_gnt", 32'(gnt), 0);
        check("t5_async_busy", 32'(busy), 0);
        check("t5_async_start", 32'(tx_start), 0);
        check("t5_async_done", 32'(done), 0);
        check("t5_async_wdata", 32'(wdata), 0);
        repeat (2) @(negedge clk);
        i_rst_n = 1'b1;
        req = 2'b10;
        push_word(0, 3'b010, 32'h44332211, 4);
        @(negedge clk);
        check("t5_gnt_req1", 32'(gnt), 32'h2);
        check("t5_first_byte", 32'(wdata), 32'h11);
        req = 2'b00;
        wait_ev(1, "t5_done_seen");
        @(negedge clk);

        // 6: three requesters, 16-bit words
        push_word(1, 3'b001, 32'hB0A0, 2);
        push_word(1, 3'b010, 32'hB1A1, 2);
        push_word(1, 3'b100, 32'hB2A2, 2);
        push_word(1, 3'b001, 32'hB0A0, 2);
        req3 = 3'b111;
        for (int g = 0; g < 4; g++) begin
            wait_ev(3, "t6_gnt_seen");
            check("t6_gnt_order", 32'(gnt3), 32'(1 << (g % 3)));
            if (g == 3) req3 = 3'b000;
            wait_ev(4, "t6_done_seen");
            @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("main_bytes_left", 32'(q_main.size()), 0);
        check("main_dones_left", 32'(qd_main.size()), 0);
        check("n3_bytes_left", 32'(q3.size()), 0);
        check("n3_dones_left", 32'(qd3.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
